// File: rtl/mdu_iter_if.sv
// mdu_iter_if: operand/opcode/start request and Busy/HI/LO result bundle of the multiply/divide unit.
interface mdu_iter_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output A, B, MDUOp, Start, input Busy, HI, LO);
    modport slave (input A, B, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: fixed-latency multiply/divide unit with HI/LO registers.
// The result is computed on Start, staged, then committed to HI/LO when Busy falls.
module mdu_iter #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       rst_n,
    mdu_iter_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        busy;
    logic [31:0] hi, lo, st_hi, st_lo;
    logic [31:0] a, b, ua, ub, q, r, sq, sr;
    logic [3:0]  op;
    logic [63:0] smul, umul, res;
    logic        is_mul, is_md, sgn;
    assign a = bus.A;
    assign b = bus.B;
    assign op = bus.MDUOp;
    assign bus.Busy = busy;
    assign bus.HI = hi;
    assign bus.LO = lo;
    assign is_mul = op == OP_MULT || op == OP_MULTU;
    assign is_md = is_mul || op == OP_DIV || op == OP_DIVU;
    assign sgn = op == OP_DIV;
    // Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        umul = {32'd0, a} * {32'd0, b};
        ua = (sgn && a[31]) ? -a : a;
        ub = (sgn && b[31]) ? -b : b;
        q = (ub == 32'd0) ? 32'd0 : ua / ub;
        r = (ub == 32'd0) ? 32'd0 : ua % ub;
        sq = (sgn && (a[31] ^ b[31])) ? -q : q;
        sr = (sgn && a[31]) ? -r : r;
        res = is_mul ? ((op == OP_MULT) ? smul : umul) : ((b == 32'd0) ? {hi, lo} : {sr, sq});
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 4'd0;
            busy <= 1'b0;
            hi <= 32'd0;
            lo <= 32'd0;
            st_hi <= 32'd0;
            st_lo <= 32'd0;
        end else if (state == IDLE) begin
            if (bus.Start && is_md) begin
                {st_hi, st_lo} <= res;
                cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                busy <= 1'b1;
                state <= RUN;
            end else if (bus.Start && op == OP_MTHI) begin
                hi <= a;
            end else if (bus.Start && op == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi <= st_hi;
                lo <= st_lo;
                busy <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter; stimulus pushes model results, a negedge monitor pops them
// whenever Busy falls or an MTHI/MTLO lands.
module tb_mdu_iter;
    localparam int MC = 5;
    localparam int DC = 10;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mdu_iter_if bus();
    mdu_iter #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rem = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] cur);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return 64'(ua * ub);
            4'd3: return (b == 32'd0) ? cur : {32'(sa % sb), 32'(sa / sb)};
            default: return (b == 32'd0) ? cur : {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction
    // One cycle of stimulus; the model tracks acceptance and remaining Busy cycles on its own.
    task automatic cyc(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = st && rem == 0;
        bus.Start = st;
        bus.MDUOp = op;
        bus.A = a;
        bus.B = b;
        if (acc && op >= 4'd1 && op <= 4'd4) begin
            {m_hi, m_lo} = ref_md(op, a, b, {m_hi, m_lo});
            rem = (op <= 4'd2) ? MC : DC;
            exp_q.push_back('{m_hi, m_lo, rem});
        end else begin
            if (acc && op == 4'd5) begin
                m_hi = a;
                exp_q.push_back('{m_hi, m_lo, 0});
            end else if (acc && op == 4'd6) begin
                m_lo = a;
                exp_q.push_back('{m_hi, m_lo, 0});
            end
            if (rem > 0) rem--;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
    endtask
    task automatic drain();
        while (rem > 0) idle(1);
    endtask
    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int bcnt = 0;
        bit pb = 0;
        bit mt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
                pb = 0;
                mt = 0;
            end else begin
                if ((pb && !bus.Busy) || mt) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_result: HI=%h LO=%h with nothing pending", bus.HI, bus.LO);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_hi", bus.HI, e.hi);
                        chk("sb_lo", bus.LO, e.lo);
                        if (!mt) chk("sb_busy_len", 32'(bcnt), 32'(e.len));
                    end
                end
                mt = bus.Start && !bus.Busy && (bus.MDUOp == 4'd5 || bus.MDUOp == 4'd6);
                bcnt = bus.Busy ? bcnt + 1 : 0;
                if (bcnt == 16) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL busy_stuck: Busy high 16 cycles, required at most %0d", DC);
                end
                pb = bus.Busy;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        #12;
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_hi", bus.HI, 32'd0);
        chk("reset_lo", bus.LO, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Reset mid-operation discards the in-flight product and clears HI/LO at once.
        cyc(1'b1, 4'd5, 32'h55, 32'd0);
        cyc(1'b1, 4'd1, 32'd3, 32'd4);
        idle(1);
        chk("midop_busy_before", {31'd0, bus.Busy}, 32'd1);
        bus.Start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midop_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midop_hi", bus.HI, 32'd0);
        chk("midop_lo", bus.LO, 32'd0);
        exp_q.delete();
        rem = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        chk("post_reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("post_reset_hi", bus.HI, 32'd0);
        chk("post_reset_lo", bus.LO, 32'd0);
        cyc(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_t1", {31'd0, bus.Busy}, 32'd1);
        idle(MC - 1);
        chk("mult_busy_tN", {31'd0, bus.Busy}, 32'd1);
        idle(1);
        chk("mult_busy_done", {31'd0, bus.Busy}, 32'd0);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        cyc(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3);
        drain();
        chk("multu_hi", bus.HI, 32'h0000_0002);
        chk("multu_lo", bus.LO, 32'hFFFF_FFFA);
        cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
        drain();
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        cyc(1'b1, 4'd4, 32'd7, 32'd2);
        drain();
        chk("divu_hi", bus.HI, 32'd1);
        chk("divu_lo", bus.LO, 32'd3);
        cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        chk("div_ovf_hi", bus.HI, 32'd0);
        chk("div_ovf_lo", bus.LO, 32'h8000_0000);
        cyc(1'b1, 4'd5, 32'h1234, 32'd0);
        cyc(1'b1, 4'd6, 32'h5678, 32'd0);
        cyc(1'b1, 4'd4, 32'd99, 32'd0);
        idle(DC - 1);
        chk("div0_busy", {31'd0, bus.Busy}, 32'd1);
        idle(1);
        chk("div0_hi", bus.HI, 32'h1234);
        chk("div0_lo", bus.LO, 32'h5678);
        // MTLO while busy must be dropped; MTHI on the falling cycle of Busy is a legal start.
        cyc(1'b1, 4'd1, 32'd6, 32'd7);
        idle(2);
        cyc(1'b1, 4'd6, 32'hDEAD, 32'd0);
        drain();
        cyc(1'b1, 4'd5, 32'hBEEF, 32'd0);
        chk("mthi_fall_hi", bus.HI, 32'hBEEF);
        chk("mthi_fall_lo", bus.LO, 32'd42);
        chk("mthi_fall_busy", {31'd0, bus.Busy}, 32'd0);
        cyc(1'b1, 4'd1, 32'd2, 32'd3);
        drain();
        chk("b2b_gap_busy", {31'd0, bus.Busy}, 32'd0);
        cyc(1'b1, 4'd3, 32'd100, 32'd7);
        chk("b2b_restart_busy", {31'd0, bus.Busy}, 32'd1);
        drain();
        chk("b2b_hi", bus.HI, 32'd2);
        chk("b2b_lo", bus.LO, 32'd14);
        for (int i = 0; i < 800; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            cyc($urandom_range(0, 2) == 0, op, rnd_word(), rnd_word());
        end
        drain();
        idle(3);
        chk("final_hi", bus.HI, m_hi);
        chk("final_lo", bus.LO, m_lo);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. Sits in the EX stage beside the ALU and handles MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Operands and opcode are accepted on a Start pulse. Busy is asserted for a fixed latency, and the result is committed to HI/LO at the end of that latency.
- The hazard unit stalls any MFHI/MFLO/MD-class instruction while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5: number of Busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10: number of Busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- A, input, 32: rs operand.
- B, input, 32: rt operand.
- MDUOp, input, 4: 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO; all other codes = none.
- Start, input, 1: qualifies MDUOp/A/B for one cycle.
- Busy, output, 1: registered; high while a mult/div is in flight.
- HI, output, 32: registered HI register.
- LO, output, 32: registered LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - HI=0, LO=0, Busy=0, counter=0, state=IDLE, staged result=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN (a 4-bit down-counter cnt tracks progress).
- IDLE, Start=1, MDUOp=MULT/MULTU/DIV/DIVU:
  - At the edge, latch the full 64-bit result into staging {st_hi, st_lo}.
  - Load cnt = latency.
  - Busy=1 from the next cycle.
  - Go to RUN.
- IDLE, Start=1, MDUOp=MTHI/MTLO: HI<=A (or LO<=A) at the edge. Busy stays 0; no state change.
- IDLE, Start=0, or MDUOp = none/undefined: no change.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1: HI<=st_hi, LO<=st_lo, Busy<=0, go to IDLE.
  - Result: Start at cycle t gives Busy high for cycles t+1..t+N, and the new HI/LO are visible with Busy=0 in cycle t+N+1.
- Start=1 while Busy=1 (any op, including MTHI/MTLO): ignored entirely. The pipeline must not issue it; the bench checks that HI/LO are unaffected.
- Start on the cycle Busy falls: Busy is already 0, so this is a legal IDLE start; back-to-back ops are allowed with no bubble.
- Arithmetic:
  - MULT: signed 32x32, {HI,LO} = 64-bit product.
  - MULTU: unsigned 32x32, {HI,LO} = 64-bit product.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder, carrying the sign of the dividend.
  - DIVU: unsigned; LO=A/B, HI=A%B.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Divide by zero (B==0, DIV or DIVU): the full latency still runs with Busy asserted, and HI/LO are left unchanged at commit.
- A/B may change after the Start cycle; only the values at the Start edge matter.
- MTHI/MTLO never disturb the other register.

Test Plan:
- Reset mid-op: MULT 3*4 starts, rst_n pulled low at cycle t+2 → Busy=0, HI=LO=0 immediately; after release, HI/LO stay 0 and Busy stays 0.
- Signed MULT, A=0xFFFFFFFE (-2), B=3, Start at t → Busy=1 for t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=-7 (0xFFFFFFF9), B=2 → after 10 Busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU, A=7, B=2 → LO=3, HI=1.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU with B=0 after MTHI 0x1234, MTLO 0x5678 → Busy for 10 cycles, then HI=0x1234, LO=0x5678.
- Busy interference: during a MULT, pulse Start with MTLO A=0xDEAD → ignored, final LO is the product. Then Start MTHI 0xBEEF on the cycle Busy falls → HI=0xBEEF next cycle, Busy stays 0.
- Back-to-back: MULT 2*3 → Busy falls → immediately DIV 100/7 → Busy continuous except 0 for exactly one cycle; final LO=14, HI=2.
